// File: rtl/midi_byte_parser.sv
// MIDI byte parser: pops raw bytes from a syn_fifo and assembles channel-voice messages.
// Define MIDI_RUNNING_STATUS_EN to keep running status after a message completes.
module midi_byte_parser #(
  parameter int DROP_CNT_W    = 8,
  parameter int NOTE_OFF_CONV = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd,
  input  logic                  fifo_empty,
  input  logic [7:0]            fifo_data,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic [2:0]            msg_type,
  output logic [3:0]            msg_chan,
  output logic [6:0]            msg_data0,
  output logic [6:0]            msg_data1,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PARSE,
    S_HOLD
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_fifo_rd;

  logic [6:0]            r_status;      // status byte without its always-set msb
  logic                  r_status_vld;
  logic                  r_idx;
  logic [6:0]            r_data0;
  logic                  r_msg_valid;
  logic [2:0]            r_msg_type;
  logic [3:0]            r_msg_chan;
  logic [6:0]            r_msg_data0;
  logic [6:0]            r_msg_data1;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  logic                  w_is_data;
  logic                  w_is_sys;
  logic                  w_is_status;
  logic                  w_need_one;
  logic                  w_complete;
  logic                  w_accept;
  logic [6:0]            w_d0;
  logic [6:0]            w_d1;
  logic [2:0]            w_msg_type;

  assign w_is_data   = ~fifo_data[7];
  assign w_is_sys    = (fifo_data[7:3] == 5'b11110);
  assign w_is_status = fifo_data[7] && (fifo_data[6:4] != 3'b111);
  // Program change (0xC) and channel pressure (0xD) carry a single data byte.
  assign w_need_one  = (r_status[6:4] == 3'b100) || (r_status[6:4] == 3'b101);
  assign w_complete  = (r_state == S_PARSE) && w_is_data && r_status_vld &&
                       (w_need_one || r_idx);
  assign w_accept    = r_msg_valid && msg_ready;
  assign w_d0        = w_need_one ? fifo_data[6:0] : r_data0;
  assign w_d1        = w_need_one ? 7'd0 : fifo_data[6:0];

  always_comb begin
    w_msg_type = r_status[6:4];
    if ((NOTE_OFF_CONV != 0) && (r_status[6:4] == 3'd1) && (w_d1 == 7'd0)) begin
      w_msg_type = 3'd0;
    end
  end

  // NOTE: synchronous reset -- rst is only looked at on the clock edge, so it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every variable gets its default before the case, so no latch can be inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_fifo_rd   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!fifo_empty && !r_msg_valid) begin
          w_fifo_rd   = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: w_state_nxt = S_PARSE;
      S_PARSE: w_state_nxt = w_complete ? S_HOLD : S_IDLE;
      S_HOLD:  if (w_accept) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Reset must also suppress the combinational strobe, not just the state.
  assign fifo_rd = w_fifo_rd & ~rst;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_status     <= '0;
      r_status_vld <= 1'b0;
      r_idx        <= 1'b0;
      r_data0      <= '0;
      r_msg_valid  <= 1'b0;
      r_msg_type   <= '0;
      r_msg_chan   <= '0;
      r_msg_data0  <= '0;
      r_msg_data1  <= '0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_msg_valid <= 1'b0;
      end
      if (r_state == S_PARSE) begin
        if (w_is_status) begin
          r_status     <= fifo_data[6:0];
          r_status_vld <= 1'b1;
          r_idx        <= 1'b0;
        end else if (w_is_sys) begin
          r_status_vld <= 1'b0;
          r_idx        <= 1'b0;
        end else if (w_is_data) begin
          if (!r_status_vld) begin
            if (r_drop_cnt != {DROP_CNT_W{1'b1}}) begin
              r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
            end
          end else if (w_complete) begin
            r_msg_valid <= 1'b1;
            r_msg_type  <= w_msg_type;
            r_msg_chan  <= r_status[3:0];
            r_msg_data0 <= w_d0;
            r_msg_data1 <= w_d1;
            r_idx       <= 1'b0;
`ifndef MIDI_RUNNING_STATUS_EN
            r_status_vld <= 1'b0;
`endif
          end else begin
            r_data0 <= fifo_data[6:0];
            r_idx   <= 1'b1;
          end
        end
        // Realtime bytes (0xF8-0xFF) fall through and leave everything untouched.
      end
    end
  end

  assign msg_valid = r_msg_valid;
  assign msg_type  = r_msg_type;
  assign msg_chan  = r_msg_chan;
  assign msg_data0 = r_msg_data0;
  assign msg_data1 = r_msg_data1;
  assign drop_cnt  = r_drop_cnt;

endmodule
